// File: rtl/line_fill_buffer_if.sv
// Bundle between a line fill buffer and its requester/memory side.
// The requester drives start/base_addr; memory answers mem_read with mem_resp/mem_rdata.
interface line_fill_buffer_if #(
  parameter int WIDTH = 16
);
  // Handshake: mem_read stays high with a stable mem_address until memory returns
  // a single-cycle mem_resp carrying mem_rdata; that edge completes the transfer.
  logic                   start;
  logic [15:0]            base_addr;
  logic                   mem_read;
  logic [15:0]            mem_address;
  logic [WIDTH-1:0]       mem_rdata;
  logic                   mem_resp;
  logic [16*WIDTH-1:0]    line_out;
  logic [3:0]             word_idx;
  logic                   busy;
  logic                   done;

  modport master (
    output start, base_addr, mem_rdata, mem_resp,
    input  mem_read, mem_address, line_out, word_idx, busy, done
  );

  modport slave (
    input  start, base_addr, mem_rdata, mem_resp,
    output mem_read, mem_address, line_out, word_idx, busy, done
  );
endinterface

// File: rtl/line_fill_buffer.sv
// Fetches a 16-word cache line one word at a time and presents it assembled on line_out.
// Moore FSM IDLE -> FILL -> DONE; state is exposed on state_dbg.
module line_fill_buffer #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  line_fill_buffer_if.slave   bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      line_base;
  logic [3:0]       word_idx;
  logic [WIDTH-1:0] words [16];
  logic             mem_read_q;
  logic             busy_q;
  logic             done_q;
  logic [16*WIDTH-1:0] line_flat;

  // Outputs are registered alongside the state so they always match the state just entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_base  <= '0;
      word_idx   <= '0;
      mem_read_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        words[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            line_base  <= {bus.base_addr[15:5], 5'b0};
            word_idx   <= 4'd0;
            state      <= FILL;
            mem_read_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        FILL: begin
          if (bus.mem_resp) begin
            words[word_idx] <= bus.mem_rdata;
            // Natural 4-bit wrap returns the index to 0 after the last word.
            word_idx        <= word_idx + 4'd1;
            if (word_idx == 4'd15) begin
              state      <= DONE;
              mem_read_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          mem_read_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          mem_read_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    line_flat = '0;
    for (int k = 0; k < 16; k++) begin
      line_flat[WIDTH*k +: WIDTH] = words[k];
    end
  end

  assign bus.line_out    = line_flat;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = {line_base[15:5], word_idx, 1'b0};
  assign bus.word_idx    = word_idx;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed-plus-random bench for line_fill_buffer against a word-array line model.
module tb_line_fill_buffer;
  localparam int WIDTH = 16;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;
  logic [WIDTH-1:0] model_line [16];

  line_fill_buffer_if #(.WIDTH(WIDTH)) bus ();

  line_fill_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[WIDTH*k +: WIDTH] = model_line[k];
    return v;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 16; k++) model_line[k] = '0;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One line fill. stall<0 picks a random 0..3 wait per word; abort_after>=0 resets
  // right after that word is captured.
  task automatic run_fill(input logic [15:0] base, input int stall, input bit seq_data,
                          input bit noise, input bit hold, input int abort_after);
    logic [15:0]      exp_addr;
    logic [WIDTH-1:0] d;
    int               st;
    bus.start     = 1'b1;
    bus.base_addr = base;
    step();
    bus.start = hold;
    for (int k = 0; k < 16; k++) begin
      exp_addr = {base[15:5], 5'b0} + 16'(2 * k);
      st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      d  = seq_data ? (16'hA000 + 16'(k)) : 16'($urandom_range(0, 65535));
      for (int s = 0; s <= st; s++) begin
        chk("fill_mem_read", 256'(bus.mem_read), 256'(1));
        chk("fill_mem_address", 256'(bus.mem_address), 256'(exp_addr));
        chk("fill_word_idx", 256'(bus.word_idx), 256'(k));
        chk("fill_busy", 256'(bus.busy), 256'(1));
        chk("fill_done", 256'(bus.done), 256'(0));
        if (noise) begin
          bus.start     = 1'($urandom_range(0, 1));
          bus.base_addr = 16'hFFE0;
        end
        if (s == st) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = d;
        end
        step();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 16'($urandom_range(0, 65535));
      end
      bus.start = hold;
      model_line[k] = d;
      if (k == abort_after) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_model();
        chk("abort_mem_read", 256'(bus.mem_read), 256'(0));
        chk("abort_busy", 256'(bus.busy), 256'(0));
        chk("abort_done", 256'(bus.done), 256'(0));
        chk("abort_mem_address", 256'(bus.mem_address), 256'(0));
        chk("abort_line_out", bus.line_out, model_flat());
        for (int i = 0; i < 3; i++) begin
          step();
          chk("abort_no_done", 256'(bus.done), 256'(0));
          chk("abort_idle", 256'(bus.busy), 256'(0));
        end
        return;
      end
      chk("partial_line_out", bus.line_out, model_flat());
    end
    chk("done_pulse", 256'(bus.done), 256'(1));
    chk("done_mem_read", 256'(bus.mem_read), 256'(0));
    chk("done_busy", 256'(bus.busy), 256'(1));
    chk("done_word_idx", 256'(bus.word_idx), 256'(0));
    chk("done_line_out", bus.line_out, model_flat());
    step();
    chk("idle_done", 256'(bus.done), 256'(0));
    chk("idle_busy", 256'(bus.busy), 256'(0));
    chk("idle_mem_read", 256'(bus.mem_read), 256'(0));
    chk("idle_line_out", bus.line_out, model_flat());
  endtask

  task automatic spurious_idle_resp();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 16'($urandom_range(0, 65535));
      step();
      chk("spur_busy", 256'(bus.busy), 256'(0));
      chk("spur_mem_read", 256'(bus.mem_read), 256'(0));
      chk("spur_line_out", bus.line_out, model_flat());
    end
    bus.mem_resp = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_model();
    // reset wins over start and mem_resp in the same cycle
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.base_addr = 16'h5555;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_mem_read", 256'(bus.mem_read), 256'(0));
      chk("rst_mem_address", 256'(bus.mem_address), 256'(0));
      chk("rst_busy", 256'(bus.busy), 256'(0));
      chk("rst_done", 256'(bus.done), 256'(0));
      chk("rst_word_idx", 256'(bus.word_idx), 256'(0));
      chk("rst_line_out", bus.line_out, 256'(0));
    end
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.mem_resp = 1'b0;
    step();
    chk("post_rst_busy", 256'(bus.busy), 256'(0));

    run_fill(16'h1234, 0, 1'b1, 1'b0, 1'b0, -1);   // full fill, sequential data
    spurious_idle_resp();
    run_fill(16'h4000, 3, 1'b0, 1'b0, 1'b0, -1);   // stalled memory
    run_fill(16'h2468, -1, 1'b0, 1'b1, 1'b0, -1);  // start/base_addr noise during fill
    spurious_idle_resp();
    run_fill(16'h8000, 0, 1'b0, 1'b0, 1'b1, -1);   // start held high through DONE
    run_fill(16'h9100, -1, 1'b0, 1'b0, 1'b0, -1);
    run_fill(16'h3000, 1, 1'b0, 1'b0, 1'b0, 7);    // reset after word 7
    run_fill(16'h7777, -1, 1'b0, 1'b0, 1'b0, -1);
    run_fill(16'hFFFF, -1, 1'b0, 1'b0, 1'b0, -1);  // top-of-space line
    spurious_idle_resp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
